// File: rtl/sprite_pkg.sv
// Shared sprite-rendering definitions, used by the player, background and
// other-player renderers.
//   SPR_COLOR_BITS : default pixel colour width
//   SPR_COORD_W    : default raster coordinate width
//   SPR_KEY_COLOR  : colour value treated as transparent
//   coord_t, rgb_t : raster coordinate and pixel colour types
package sprite_pkg;

    localparam int unsigned SPR_COLOR_BITS = 24;
    localparam int unsigned SPR_COORD_W    = 10;
    localparam logic [23:0] SPR_KEY_COLOR  = 24'hFF00FF;

    typedef logic [SPR_COORD_W-1:0]    coord_t;
    typedef logic [SPR_COLOR_BITS-1:0] rgb_t;

endpackage

// File: rtl/sprite_blink_ctrl.sv
// Damage-blink controller: counts frames while blinking is enabled and
// toggles sprite visibility every BLINK_FRAMES frames.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   frame_start_i   : one-cycle start-of-vblank pulse
//   blink_en_i      : blinking enabled; low forces the sprite visible
//   visible_o       : sprite currently visible
module sprite_blink_ctrl #(
    parameter int unsigned BLINK_FRAMES = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic frame_start_i,
    input  logic blink_en_i,
    output logic visible_o
);
    import sprite_pkg::*;

    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vis_q, vis_d;

    always_comb begin
        cnt_d = cnt_q;
        vis_d = vis_q;
        if (!blink_en_i) begin
            cnt_d = '0;
            vis_d = 1'b1;
        end else if (frame_start_i) begin
            if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                cnt_d = '0;
                vis_d = ~vis_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            vis_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            vis_q <= vis_d;
        end
    end

    assign visible_o = vis_q;

endmodule

// File: rtl/player_sprite_renderer.sv
// Player sprite pixel stage: maps the raster position onto the sprite box,
// addresses the asynchronous sprite ROM, applies colour-key transparency,
// mirroring and damage blink, and composites over the background pixel.
// Two-cycle latency from hcount/vcount/de_in/bg_rgb to rgb_out/de_out/sprite_hit.
//   clk, rst_n            : pixel clock, asynchronous active-low reset
//   frame_start           : start-of-vblank pulse; latches pos_x/pos_y/facing_left
//   blink_en              : invulnerability blink enable
//   hcount, vcount, de_in : current raster position and display enable
//   bg_rgb                : background colour for the current pixel
//   rom_addr / rom_dout   : sprite ROM address out, combinational data back
//   rgb_out, de_out       : composited pixel and aligned display enable
//   sprite_hit            : opaque visible sprite pixel at rgb_out
module player_sprite_renderer
    import sprite_pkg::*;
#(
    parameter int unsigned ADDRESS      = 11,
    parameter int unsigned COLOR_BITS   = SPR_COLOR_BITS,
    parameter int unsigned SPRITE_W     = 32,
    parameter int unsigned SPRITE_H     = 64,
    parameter int unsigned COORD_W      = SPR_COORD_W,
    parameter logic [23:0] KEY_COLOR    = SPR_KEY_COLOR,
    parameter int unsigned BLINK_FRAMES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [COORD_W-1:0]    pos_x,
    input  logic [COORD_W-1:0]    pos_y,
    input  logic                  facing_left,
    input  logic                  blink_en,
    input  logic [COORD_W-1:0]    hcount,
    input  logic [COORD_W-1:0]    vcount,
    input  logic                  de_in,
    input  logic [COLOR_BITS-1:0] bg_rgb,
    output logic [ADDRESS-1:0]    rom_addr,
    input  logic [COLOR_BITS-1:0] rom_dout,
    output logic [COLOR_BITS-1:0] rgb_out,
    output logic                  de_out,
    output logic                  sprite_hit
);

    localparam int unsigned          COL_W = $clog2(SPRITE_W);
    localparam logic [COLOR_BITS-1:0] KEY  = COLOR_BITS'(KEY_COLOR);

    // Per-frame latched sprite placement
    logic [COORD_W-1:0]    lpos_x_q, lpos_y_q;
    logic                  lface_q;

    // Stage 1 / stage 2 pipeline registers
    logic [ADDRESS-1:0]    rom_addr_q, rom_addr_d;
    logic                  in_box_q, in_box_d;
    logic                  de1_q;
    logic [COLOR_BITS-1:0] bg1_q;
    logic [COLOR_BITS-1:0] rgb_q, rgb_d;
    logic                  de2_q;
    logic                  hit_q, hit_d;

    logic [COORD_W:0]      rel_x, rel_y;
    logic [COL_W-1:0]      col;
    logic                  visible, opaque;

    sprite_blink_ctrl #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .frame_start_i (frame_start),
        .blink_en_i    (blink_en),
        .visible_o     (visible)
    );

    // Extra top bit makes pixels left of/above the sprite wrap to large
    // unsigned values, so they fail the box compare instead of aliasing.
    always_comb begin
        rel_x      = {1'b0, hcount} - {1'b0, lpos_x_q};
        rel_y      = {1'b0, vcount} - {1'b0, lpos_y_q};
        in_box_d   = de_in && (rel_x < (COORD_W+1)'(SPRITE_W))
                           && (rel_y < (COORD_W+1)'(SPRITE_H));
        col        = lface_q ? (COL_W'(SPRITE_W - 1) - rel_x[COL_W-1:0])
                             : rel_x[COL_W-1:0];
        rom_addr_d = '0;
        if (in_box_d) begin
            rom_addr_d = ADDRESS'(rel_y) * ADDRESS'(SPRITE_W) + ADDRESS'(col);
        end
    end

    always_comb begin
        opaque = in_box_q && visible && (rom_dout != KEY);
        rgb_d  = '0;
        if (de1_q) begin
            rgb_d = opaque ? rom_dout : bg1_q;
        end
        hit_d  = opaque && de1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lpos_x_q   <= '0;
            lpos_y_q   <= '0;
            lface_q    <= 1'b0;
            rom_addr_q <= '0;
            in_box_q   <= 1'b0;
            de1_q      <= 1'b0;
            bg1_q      <= '0;
            rgb_q      <= '0;
            de2_q      <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            if (frame_start) begin
                lpos_x_q <= pos_x;
                lpos_y_q <= pos_y;
                lface_q  <= facing_left;
            end
            rom_addr_q <= rom_addr_d;
            in_box_q   <= in_box_d;
            de1_q      <= de_in;
            bg1_q      <= bg_rgb;
            rgb_q      <= rgb_d;
            de2_q      <= de1_q;
            hit_q      <= hit_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign rgb_out    = rgb_q;
    assign de_out     = de2_q;
    assign sprite_hit = hit_q;

endmodule

// File: tb/tb_player_sprite_renderer.sv
module tb_player_sprite_renderer;

    localparam int W = 32;
    localparam int H = 64;
    localparam int BLINK = 8;
    localparam logic [23:0] KEY = 24'hFF00FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  pos_x = '0, pos_y = '0;
    logic        facing_left = 1'b0;
    logic        blink_en = 1'b0;
    logic [9:0]  hcount = '0, vcount = '0;
    logic        de_in = 1'b0;
    logic [23:0] bg_rgb = '0;
    logic [10:0] rom_addr;
    logic [23:0] rom_dout;
    logic [23:0] rgb_out;
    logic        de_out;
    logic        sprite_hit;

    logic [23:0] rom [0:2047];
    assign rom_dout = rom[rom_addr];

    int checks = 0;
    int errors = 0;

    player_sprite_renderer #(
        .ADDRESS      (11),
        .COLOR_BITS   (24),
        .SPRITE_W     (W),
        .SPRITE_H     (H),
        .COORD_W      (10),
        .KEY_COLOR    (KEY),
        .BLINK_FRAMES (BLINK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .facing_left (facing_left),
        .blink_en    (blink_en),
        .hcount      (hcount),
        .vcount      (vcount),
        .de_in       (de_in),
        .bg_rgb      (bg_rgb),
        .rom_addr    (rom_addr),
        .rom_dout    (rom_dout),
        .rgb_out     (rgb_out),
        .de_out      (de_out),
        .sprite_hit  (sprite_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pixel-level rules on integers, one record in flight
    int          m_lx = 0, m_ly = 0;
    bit          m_face = 0;
    int          m_frames = 0;
    bit          p_in = 0, p_de = 0;
    int          p_addr = 0;
    logic [23:0] p_bg = '0;
    logic [10:0] e_addr = '0;
    logic [23:0] e_rgb = '0;
    bit          e_de = 0, e_hit = 0;

    initial begin : model
        int  dx, dy;
        bit  vis, opq;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_lx = 0; m_ly = 0; m_face = 0; m_frames = 0;
                p_in = 0; p_de = 0; p_addr = 0; p_bg = '0;
                e_addr = '0; e_rgb = '0; e_de = 0; e_hit = 0;
            end else begin
                vis   = ((m_frames / BLINK) % 2) == 0;
                opq   = p_in && vis && (rom[p_addr] != KEY);
                e_rgb = p_de ? (opq ? rom[p_addr] : p_bg) : 24'h0;
                e_hit = opq && p_de;
                e_de  = p_de;
                dx    = int'(hcount) - m_lx;
                dy    = int'(vcount) - m_ly;
                p_in  = de_in && dx >= 0 && dx < W && dy >= 0 && dy < H;
                p_addr = p_in ? dy * W + (m_face ? (W - 1 - dx) : dx) : 0;
                e_addr = 11'(p_addr);
                p_de  = de_in;
                p_bg  = bg_rgb;
                if (frame_start) begin
                    m_lx = int'(pos_x); m_ly = int'(pos_y); m_face = facing_left;
                end
                if (!blink_en) m_frames = 0;
                else if (frame_start) m_frames++;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("rom_addr", 32'(rom_addr), 32'(e_addr));
                chk("rgb_out", 32'(rgb_out), 32'(e_rgb));
                chk("de_out", 32'(de_out), 32'(e_de));
                chk("sprite_hit", 32'(sprite_hit), 32'(e_hit));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int h, input int v, input logic [23:0] bg);
        hcount = 10'(h); vcount = 10'(v); de_in = 1'b1; bg_rgb = bg;
    endtask

    task automatic idle();
        de_in = 1'b0; hcount = '0; vcount = '0; bg_rgb = '0;
    endtask

    task automatic frame(input int px, input int py, input logic face);
        idle();
        pos_x = 10'(px); pos_y = 10'(py); facing_left = face; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic probe(output logic hit);
        pix(105, 52, 24'h0000AA);
        tick();
        idle();
        tick();
        hit = sprite_hit;
    endtask

    initial begin : stim
        int   hits;
        logic h;
        for (int i = 0; i < 2048; i++) rom[i] = 24'(i);

        tick(); tick();
        chk("reset_rom_addr", 32'(rom_addr), 32'h0);
        chk("reset_rgb", 32'(rgb_out), 32'h0);
        chk("reset_de", 32'(de_out), 32'h0);
        chk("reset_hit", 32'(sprite_hit), 32'h0);
        rst_n = 1'b1;
        tick();

        // Forward-facing ramp pixel
        frame(100, 50, 1'b0);
        pix(105, 52, 24'hABCDEF);
        tick();
        chk("fwd_addr", 32'(rom_addr), 32'd69);
        idle();
        tick();
        chk("fwd_rgb", 32'(rgb_out), 32'h000045);
        chk("fwd_hit", 32'(sprite_hit), 32'h1);

        // Mirrored
        frame(100, 50, 1'b1);
        pix(105, 52, 24'hABCDEF);
        tick();
        chk("mirror_addr", 32'(rom_addr), 32'd90);
        idle();
        tick();
        chk("mirror_rgb", 32'(rgb_out), 32'h00005A);

        // Colour key shows background
        frame(100, 50, 1'b0);
        rom[69] = KEY;
        pix(105, 52, 24'h123456);
        tick();
        idle();
        tick();
        chk("key_rgb", 32'(rgb_out), 32'h123456);
        chk("key_hit", 32'(sprite_hit), 32'h0);
        tick();
        rom[69] = 24'd69;

        // Right-edge clip, no wrap, mid-frame position change ignored
        frame(630, 0, 1'b0);
        pos_x = 10'd0;
        hits = 0;
        for (int x = 600; x < 640; x++) begin
            pix(x, 0, 24'h00FF00); tick();
            if (sprite_hit) hits++;
        end
        for (int x = 0; x < 22; x++) begin
            pix(x, 0, 24'h00FF00); tick();
            if (sprite_hit) hits++;
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            if (sprite_hit) hits++;
        end
        chk("edge_hit_count", 32'(hits), 32'd10);

        // frame_start coincident with an active pixel uses the old position
        frame(100, 50, 1'b0);
        pos_x = 10'd0; pos_y = 10'd0; frame_start = 1'b1;
        pix(105, 52, 24'h0);
        tick();
        frame_start = 1'b0;
        chk("late_fs_addr", 32'(rom_addr), 32'd69);
        pix(5, 2, 24'h0);
        tick();
        chk("late_fs_rgb", 32'(rgb_out), 32'h000045);
        chk("new_pos_addr", 32'(rom_addr), 32'd69);
        idle();
        tick();

        // Blink sequence
        frame(100, 50, 1'b0);
        blink_en = 1'b1;
        probe(h);
        chk("blink_f0", 32'(h), 32'h1);
        for (int k = 1; k <= 20; k++) begin
            frame(100, 50, 1'b0);
            probe(h);
            chk($sformatf("blink_f%0d", k), 32'(h), ((k < 8) || (k >= 16)) ? 32'h1 : 32'h0);
        end
        for (int k = 21; k <= 24; k++) frame(100, 50, 1'b0);
        probe(h);
        chk("blink_f24", 32'(h), 32'h0);
        blink_en = 1'b0;
        tick();
        probe(h);
        chk("blink_off", 32'(h), 32'h1);

        // Asynchronous reset during opaque output
        pix(105, 52, 24'h0);
        tick();
        pix(105, 52, 24'h0);
        tick();
        chk("pre_rst_hit", 32'(sprite_hit), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rom_addr", 32'(rom_addr), 32'h0);
        chk("arst_rgb", 32'(rgb_out), 32'h0);
        chk("arst_de", 32'(de_out), 32'h0);
        chk("arst_hit", 32'(sprite_hit), 32'h0);
        idle();
        tick();
        rst_n = 1'b1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_sprite_renderer.md
Name: player_sprite_renderer

Overview:
- Pixel-pipeline stage that drives the address of the asynchronous player sprite ROM and consumes its colour output.
- Maps raster coordinates to sprite-relative coordinates against a per-frame latched player position.
- Applies colour-key transparency, horizontal mirroring and damage blinking, then composites the sprite over the incoming background pixel.
- Sits between the VGA timing/background generator and the video output register.

Parameters:
- ADDRESS, 11, sprite ROM address width; must equal clog2(SPRITE_W*SPRITE_H).
- COLOR_BITS, 24, pixel colour width (24 or 12).
- SPRITE_W, 32, sprite width in pixels (power of two).
- SPRITE_H, 64, sprite height in pixels.
- COORD_W, 10, raster coordinate width.
- KEY_COLOR, 24'hFF00FF, transparent colour key; truncated to COLOR_BITS.
- BLINK_FRAMES, 8, frames per visibility toggle while blinking.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pos_x  in  COORD_W  sprite top-left x, sampled on frame_start
- pos_y  in  COORD_W  sprite top-left y, sampled on frame_start
- facing_left  in  1  mirror sprite horizontally, sampled on frame_start
- blink_en  in  1  invulnerability blink enable
- hcount  in  COORD_W  current pixel x
- vcount  in  COORD_W  current pixel y
- de_in  in  1  display enable for the current pixel
- bg_rgb  in  COLOR_BITS  background colour for the current pixel
- rom_addr  out  ADDRESS  sprite ROM address
- rom_dout  in  COLOR_BITS  sprite ROM data; combinational from rom_addr
- rgb_out  out  COLOR_BITS  composited pixel
- de_out  out  1  de_in delayed to align with rgb_out
- sprite_hit  out  1  opaque, visible sprite pixel at rgb_out (used for collision)

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: rom_addr=0, rgb_out=0, de_out=0, sprite_hit=0.
  - State: latched pos/facing=0, blink counter=0, visible=1, pipeline valid bits=0.
- Frame latch: on a clk edge with frame_start=1, register pos_x, pos_y and facing_left. Raster math uses only the latched copies; new values take effect on the next cycle. Mid-frame input changes are ignored (no tearing).
- Stage 1 (registered):
  - rel_x = hcount - lpos_x and rel_y = vcount - lpos_y, computed in COORD_W+1 bits.
  - in_box = de_in and rel_x < SPRITE_W and rel_y < SPRITE_H, both unsigned; wrapped negatives fail the compare.
  - col = facing ? SPRITE_W-1-rel_x : rel_x.
  - rom_addr <= in_box ? rel_y*SPRITE_W + col : 0.
  - Delay in_box, de_in and bg_rgb by one register.
- Stage 2 (registered): opaque = in_box_d and visible and (rom_dout != KEY_COLOR).
  - rgb_out <= de_d ? (opaque ? rom_dout : bg_d) : 0.
  - sprite_hit <= opaque and de_d.
  - de_out <= de_d.
- Latency: hcount/vcount/de_in/bg_rgb -> rgb_out/de_out/sprite_hit is exactly 2 cycles, fully pipelined at one pixel per clock.
- Partial off-screen sprites: only the on-screen portion is drawn. Example: pos_x=630 on a 640-wide raster draws cols 0..9. No wrap to the left edge.
- Blink:
  - blink_en=0: counter=0, visible=1.
  - blink_en=1: counter increments on each frame_start. At BLINK_FRAMES-1 it wraps to 0 and visible toggles.
  - visible changes only at frame_start, never mid-frame.
  - Deasserting blink_en forces visible=1 next cycle.
- frame_start concurrent with de_in=1 (illegal timing): the pixel uses the old latched position, with no other side effects.

Decomposition:
- Package sprite_pkg: COLOR_BITS default, KEY_COLOR constant, coord_t (logic [COORD_W-1:0]) and rgb_t typedefs, shared with the background and other-player renderers.
- Sub-module sprite_blink_ctrl: the frame counter and visible toggle. Everything else stays flat.

Test Plan:
- ROM loaded with ramp (addr[23:0]=addr); pos=(100,50), facing=0; pixel (105,52) -> two cycles later rom_addr was 69, rgb_out=24'h000045, sprite_hit=1.
- Same setup, facing_left=1 latched at frame_start; pixel (105,52) -> rom_addr=2*32+26=90, rgb_out=24'h00005A.
- ROM word 69 = 24'hFF00FF; bg_rgb=24'h123456 at (105,52) -> rgb_out=24'h123456, sprite_hit=0.
- pos_x=630, pos_y=0; sweep row 0 -> sprite_hit=1 for hcount 630..639 only; hcount=0..21 gives no hit (no wrap). pos_x change mid-frame has no effect until the next frame_start.
- blink_en=1, 20 frame_start pulses -> visible=1 for frames 0-7, 0 for frames 8-15, 1 from frame 16. Deassert blink_en -> visible=1 next cycle.
- Assert rst_n=0 mid-line during opaque output -> rgb_out, de_out, sprite_hit and rom_addr read 0 immediately, without waiting for a clock edge.
